// File: rtl/arm_regfile_sb.sv
// arm_regfile_sb: parametrised ARM-style register file with one write port,
// two combinational read ports, a redirected PC read path, optional
// write-to-read bypass and a per-register pending-load scoreboard.
// The hazard unit stalls on busy1/busy2 while a load to a source register
// is still outstanding.
module arm_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5,
  parameter int PC_IDX   = 15,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [DATA_W-1:0] r15_in,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  output logic              any_pend
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] set_hit;
  logic [NUM_REGS-1:0] clr_hit;

  // Per-register decode of write, pending-set and pending-clear strobes.
  // The PC entry is excluded from writes and sets so it never holds state;
  // out-of-range addresses match no index and are therefore dropped.
  always_comb begin
    wr_hit  = '0;
    set_hit = '0;
    clr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i]  = we3 && (a3 == ADDR_W'(i)) && (i != PC_IDX);
      set_hit[i] = pend_set && (pend_addr == ADDR_W'(i)) && (i != PC_IDX);
      clr_hit[i] = we3 && (a3 == ADDR_W'(i));
    end
  end

  // Register and scoreboard state; a set beats a same-cycle clear so a new
  // load issued while the old one retires keeps the register busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wd3;
        end
        if (set_hit[i]) begin
          pend[i] <= 1'b1;
        end else if (clr_hit[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  logic [DATA_W-1:0] stored1, stored2;
  logic              pend_at1, pend_at2;
  logic              in_range1, in_range2;
  logic              byp1, byp2;

  // Read port 1: PC redirect, out-of-range zero, bypass, then stored value.
  always_comb begin
    stored1   = '0;
    pend_at1  = 1'b0;
    in_range1 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a1 == ADDR_W'(i)) begin
        stored1   = regs[i];
        pend_at1  = pend[i];
        in_range1 = 1'b1;
      end
    end
    byp1 = (BYPASS != 0) && we3 && (a3 == a1);
    if (a1 == PC_A) begin
      rd1   = r15_in;
      busy1 = 1'b0;
    end else if (!in_range1) begin
      rd1   = '0;
      busy1 = 1'b0;
    end else if (byp1) begin
      rd1   = wd3;
      busy1 = 1'b0;
    end else begin
      rd1   = stored1;
      busy1 = pend_at1;
    end
  end

  // Read port 2: same resolution order as port 1, fully independent.
  always_comb begin
    stored2   = '0;
    pend_at2  = 1'b0;
    in_range2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a2 == ADDR_W'(i)) begin
        stored2   = regs[i];
        pend_at2  = pend[i];
        in_range2 = 1'b1;
      end
    end
    byp2 = (BYPASS != 0) && we3 && (a3 == a2);
    if (a2 == PC_A) begin
      rd2   = r15_in;
      busy2 = 1'b0;
    end else if (!in_range2) begin
      rd2   = '0;
      busy2 = 1'b0;
    end else if (byp2) begin
      rd2   = wd3;
      busy2 = 1'b0;
    end else begin
      rd2   = stored2;
      busy2 = pend_at2;
    end
  end

  // Summary of outstanding loads for the hazard unit.
  always_comb begin
    any_pend = |pend;
  end

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Directed bench for arm_regfile_sb. Two instances share all inputs: one
// with write-to-read bypass enabled and one without, so both read
// behaviours are observed on the same stimulus.
module tb_arm_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          we3;
  logic [AW-1:0] a1, a2, a3, pend_addr;
  logic [DW-1:0] wd3, r15_in;
  logic          pend_set;
  logic [DW-1:0] rd1, rd2, rd1_nb, rd2_nb;
  logic          busy1, busy2, any_pend;
  logic          busy1_nb, busy2_nb, any_pend_nb;

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  arm_regfile_sb #(.DATA_W(DW), .NUM_REGS(16), .ADDR_W(AW), .PC_IDX(15), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .r15_in(r15_in), .pend_set(pend_set), .pend_addr(pend_addr),
    .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2), .any_pend(any_pend)
  );

  arm_regfile_sb #(.DATA_W(DW), .NUM_REGS(16), .ADDR_W(AW), .PC_IDX(15), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .r15_in(r15_in), .pend_set(pend_set), .pend_addr(pend_addr),
    .rd1(rd1_nb), .rd2(rd2_nb), .busy1(busy1_nb), .busy2(busy2_nb), .any_pend(any_pend_nb)
  );

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; a3 = '0; wd3 = '0;
    pend_set = 1'b0; pend_addr = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // Load R3 and mark it pending, then reset while write/set are also driven.
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'hDEADBEEF;
    tick();
    idle_inputs();
    pend_set = 1'b1; pend_addr = 5'd3;
    tick();
    idle_inputs();
    a1 = 5'd3;
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_rd1 got %h exp %h", rd1, 32'hDEADBEEF); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL pre_reset_busy1 got %b exp 1", busy1); end
    reset = 1'b1;
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'h11111111;
    pend_set = 1'b1; pend_addr = 5'd5;
    tick();
    reset = 1'b0;
    idle_inputs();
    a1 = 5'd3; a2 = 5'd5;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd1, 32'h0); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_write_ignored got %h exp %h", rd2, 32'h0); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_set_ignored got %b exp 0", busy2); end
    checks++; if (any_pend !== 1'b0) begin errors++; $display("FAIL reset_any_pend got %b exp 0", any_pend); end
    checks++; if (any_pend_nb !== 1'b0) begin errors++; $display("FAIL reset_any_pend_nb got %b exp 0", any_pend_nb); end
  endtask

  task automatic test_write_bypass();
    we3 = 1'b1; a3 = 5'd4; wd3 = 32'h12345678;
    a1 = 5'd4; a2 = 5'd4;
    #1;
    checks++; if (rd1 !== 32'h12345678) begin errors++; $display("FAIL bypass_rd1 got %h exp %h", rd1, 32'h12345678); end
    checks++; if (rd2 !== 32'h12345678) begin errors++; $display("FAIL bypass_rd2 got %h exp %h", rd2, 32'h12345678); end
    checks++; if (rd1_nb !== 32'h0) begin errors++; $display("FAIL nobypass_rd1 got %h exp %h", rd1_nb, 32'h0); end
    tick();
    idle_inputs();
    #1;
    checks++; if (rd1 !== 32'h12345678) begin errors++; $display("FAIL write_rd1 got %h exp %h", rd1, 32'h12345678); end
    checks++; if (rd1_nb !== 32'h12345678) begin errors++; $display("FAIL write_rd1_nb got %h exp %h", rd1_nb, 32'h12345678); end
  endtask

  task automatic test_pc();
    r15_in = 32'h00000108; a2 = 5'd15;
    #1;
    checks++; if (rd2 !== 32'h00000108) begin errors++; $display("FAIL pc_rd2 got %h exp %h", rd2, 32'h108); end
    we3 = 1'b1; a3 = 5'd15; wd3 = 32'hFFFFFFFF; r15_in = 32'h0000010C;
    #1;
    checks++; if (rd2 !== 32'h0000010C) begin errors++; $display("FAIL pc_no_bypass got %h exp %h", rd2, 32'h10C); end
    tick();
    idle_inputs();
    a1 = 5'd4;
    #1;
    checks++; if (rd2 !== 32'h0000010C) begin errors++; $display("FAIL pc_after_write got %h exp %h", rd2, 32'h10C); end
    checks++; if (rd2_nb !== 32'h0000010C) begin errors++; $display("FAIL pc_after_write_nb got %h exp %h", rd2_nb, 32'h10C); end
    checks++; if (rd1 !== 32'h12345678) begin errors++; $display("FAIL pc_write_side_effect got %h exp %h", rd1, 32'h12345678); end
  endtask

  task automatic test_scoreboard();
    pend_set = 1'b1; pend_addr = 5'd7;
    tick();
    idle_inputs();
    a1 = 5'd7; a2 = 5'd7;
    #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy1 got %b exp 1", busy1); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL sb_busy2 got %b exp 1", busy2); end
    checks++; if (any_pend !== 1'b1) begin errors++; $display("FAIL sb_any_pend got %b exp 1", any_pend); end
    repeat (3) tick();
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_hold_busy1 got %b exp 1", busy1); end
    checks++; if (any_pend !== 1'b1) begin errors++; $display("FAIL sb_hold_any_pend got %b exp 1", any_pend); end
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h000000A5;
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_fwd_busy1 got %b exp 0", busy1); end
    checks++; if (rd1 !== 32'h000000A5) begin errors++; $display("FAIL sb_fwd_rd1 got %h exp %h", rd1, 32'hA5); end
    checks++; if (busy1_nb !== 1'b1) begin errors++; $display("FAIL sb_nofwd_busy1 got %b exp 1", busy1_nb); end
    checks++; if (any_pend !== 1'b1) begin errors++; $display("FAIL sb_fwd_any_pend got %b exp 1", any_pend); end
    tick();
    idle_inputs();
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_clear_busy1 got %b exp 0", busy1); end
    checks++; if (busy1_nb !== 1'b0) begin errors++; $display("FAIL sb_clear_busy1_nb got %b exp 0", busy1_nb); end
    checks++; if (any_pend !== 1'b0) begin errors++; $display("FAIL sb_clear_any_pend got %b exp 0", any_pend); end
    checks++; if (rd1 !== 32'h000000A5) begin errors++; $display("FAIL sb_clear_rd1 got %h exp %h", rd1, 32'hA5); end
  endtask

  task automatic test_set_clear();
    pend_set = 1'b1; pend_addr = 5'd2;
    tick();
    pend_set = 1'b1; pend_addr = 5'd2;
    we3 = 1'b1; a3 = 5'd2; wd3 = 32'h00000055;
    tick();
    idle_inputs();
    a1 = 5'd2;
    #1;
    checks++; if (rd1 !== 32'h00000055) begin errors++; $display("FAIL setclr_rd1 got %h exp %h", rd1, 32'h55); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL setclr_busy1 got %b exp 1", busy1); end
    checks++; if (any_pend !== 1'b1) begin errors++; $display("FAIL setclr_any_pend got %b exp 1", any_pend); end
    we3 = 1'b1; a3 = 5'd2; wd3 = 32'h00000066;
    tick();
    idle_inputs();
    #1;
    checks++; if (any_pend !== 1'b0) begin errors++; $display("FAIL setclr_retire got %b exp 0", any_pend); end
  endtask

  task automatic test_out_of_range();
    a1 = 5'd20; a2 = 5'd4;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL oor_rd1 got %h exp %h", rd1, 32'h0); end
    we3 = 1'b1; a3 = 5'd20; wd3 = 32'hCAFEF00D;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL oor_no_bypass got %h exp %h", rd1, 32'h0); end
    checks++; if (rd2 !== 32'h12345678) begin errors++; $display("FAIL oor_rd2_same got %h exp %h", rd2, 32'h12345678); end
    tick();
    idle_inputs();
    a1 = 5'd2; a2 = 5'd7;
    #1;
    checks++; if (rd1 !== 32'h00000066) begin errors++; $display("FAIL oor_r2_kept got %h exp %h", rd1, 32'h66); end
    checks++; if (rd2 !== 32'h000000A5) begin errors++; $display("FAIL oor_r7_kept got %h exp %h", rd2, 32'hA5); end
    a1 = 5'd4;
    #1;
    checks++; if (rd1 !== 32'h12345678) begin errors++; $display("FAIL oor_r4_kept got %h exp %h", rd1, 32'h12345678); end
    // Low 4 bits of 20 are 4: a truncated compare would alias onto R4.
    a1 = 5'd0;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL oor_r0_kept got %h exp %h", rd1, 32'h0); end
    pend_set = 1'b1; pend_addr = 5'd15;
    tick();
    idle_inputs();
    a1 = 5'd15;
    #1;
    checks++; if (any_pend !== 1'b0) begin errors++; $display("FAIL pc_set_any_pend got %b exp 0", any_pend); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL pc_set_busy1 got %b exp 0", busy1); end
    pend_set = 1'b1; pend_addr = 5'd20;
    tick();
    idle_inputs();
    a1 = 5'd4;
    #1;
    checks++; if (any_pend !== 1'b0) begin errors++; $display("FAIL oor_set_any_pend got %b exp 0", any_pend); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL oor_set_alias_busy1 got %b exp 0", busy1); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [4];
    vals[0] = 32'h0BAD0000; vals[1] = 32'h1111AAAA; vals[2] = 32'h2222BBBB; vals[3] = 32'h3333CCCC;
    for (int i = 0; i < 4; i++) begin
      we3 = 1'b1; a3 = AW'(10 + i); wd3 = vals[i];
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      a1 = AW'(10 + i); a2 = AW'(13 - i);
      #1;
      checks++; if (rd1 !== vals[i]) begin errors++; $display("FAIL b2b_rd1[%0d] got %h exp %h", i, rd1, vals[i]); end
      checks++; if (rd2 !== vals[3 - i]) begin errors++; $display("FAIL b2b_rd2[%0d] got %h exp %h", i, rd2, vals[3 - i]); end
    end
    a1 = 5'd11; a2 = 5'd11;
    #1;
    checks++; if (rd1 !== 32'h1111AAAA || rd2 !== 32'h1111AAAA) begin
      errors++; $display("FAIL b2b_same_addr got %h/%h exp %h", rd1, rd2, 32'h1111AAAA);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    idle_inputs();
    a1 = '0; a2 = '0; r15_in = '0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_write_bypass();
    test_pc();
    test_scoreboard();
    test_set_clear();
    test_out_of_range();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
